// File: rtl/calc2_req_port.sv
// Per-port calc2 requester: serialises (cmd, op1, op2) onto the two-cycle request
// protocol, allocates 2-bit tags and turns responses or timeouts into completions.
module calc2_req_port #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 256,
   parameter int TO_W            = 9
) (
   input  logic        ifClk,
   input  logic        ifRst,
   input  logic        txn_valid,
   output logic        txn_ready,
   input  logic [3:0]  txn_cmd,
   input  logic [31:0] txn_op1,
   input  logic [31:0] txn_op2,
   output logic [3:0]  ifReq_cmd_out,
   output logic [31:0] ifReq_data_out,
   output logic [1:0]  ifReq_tag_out,
   input  logic [1:0]  ifResp_in,
   input  logic [31:0] ifData_in,
   input  logic [1:0]  ifTag_in,
   output logic        cpl_valid,
   output logic [3:0]  cpl_cmd,
   output logic [1:0]  cpl_tag,
   output logic [1:0]  cpl_resp,
   output logic [31:0] cpl_data,
   output logic        cpl_timeout,
   output logic        err_unexpected,
   output logic [2:0]  outstanding
);

   localparam int NUM_TAGS = 4;
   localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_EXP = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND1 = 2'd1,
      SEND2 = 2'd2
   } state_t;

   state_t      state_reg;
   logic [3:0]  req_cmd_reg;
   logic [31:0] req_data_reg;
   logic [1:0]  req_tag_reg;
   logic [31:0] op2_reg;
   logic [1:0]  cur_tag_reg;
   logic [NUM_TAGS-1:0] busy_reg;
   logic [NUM_TAGS-1:0] busy_next;
   logic [2:0]  outstanding_reg;
   logic [2:0]  outstanding_next;

   logic        cpl_valid_reg;
   logic [3:0]  cpl_cmd_reg;
   logic [1:0]  cpl_tag_reg;
   logic [1:0]  cpl_resp_reg;
   logic [31:0] cpl_data_reg;
   logic        cpl_timeout_reg;
   logic        err_reg;

   logic [3:0]  tag_cmd [NUM_TAGS];
   logic [NUM_TAGS-1:0] expired;

   logic        resp_valid;
   logic        resp_hit;
   logic        resp_bad;
   logic [NUM_TAGS-1:0] resp_free_mask;
   logic [NUM_TAGS-1:0] free_vec;
   logic [NUM_TAGS-1:0] exp_mask;
   logic [NUM_TAGS-1:0] to_free_mask;
   logic [NUM_TAGS-1:0] alloc_mask;
   logic [1:0]  alloc_tag;
   logic        alloc_ok;
   logic [1:0]  exp_tag;
   logic        exp_any;
   logic        to_fire;
   logic        accept;
   logic        can_issue;

   assign resp_valid     = (ifResp_in == 2'd1) || (ifResp_in == 2'd2);
   assign resp_hit       = resp_valid && busy_reg[ifTag_in];
   assign resp_bad       = (ifResp_in == 2'd3) || (resp_valid && !busy_reg[ifTag_in]);
   assign resp_free_mask = resp_hit ? (4'b0001 << ifTag_in) : 4'b0000;
   // A tag released by this cycle's response may be handed out again immediately
   assign free_vec       = ~busy_reg | resp_free_mask;
   assign exp_mask       = expired & ~resp_free_mask;

   always_comb begin
      alloc_tag = 2'd0;
      alloc_ok  = 1'b0;
      exp_tag   = 2'd0;
      exp_any   = 1'b0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         if (free_vec[i]) begin
            alloc_tag = 2'(i);
            alloc_ok  = 1'b1;
         end
         if (exp_mask[i]) begin
            exp_tag = 2'(i);
            exp_any = 1'b1;
         end
      end
   end

   assign can_issue = (state_reg == IDLE) || (state_reg == SEND2);
   assign txn_ready = ifRst && can_issue && alloc_ok &&
                      (outstanding_reg < 3'(MAX_OUTSTANDING));
   assign accept    = txn_valid && txn_ready;

   // Responses take the single completion slot; an expiry waits with its counter saturated
   assign to_fire      = !resp_hit && exp_any;
   assign to_free_mask = to_fire ? (4'b0001 << exp_tag) : 4'b0000;
   assign alloc_mask   = accept ? (4'b0001 << alloc_tag) : 4'b0000;

   assign busy_next        = (busy_reg & ~resp_free_mask & ~to_free_mask) | alloc_mask;
   assign outstanding_next = outstanding_reg + 3'(accept) - 3'(resp_hit || to_fire);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_TAGS; gi++) begin : g_tag
         logic [TO_W-1:0] cnt_reg;
         logic [3:0]      cmd_reg;

         always_ff @(posedge ifClk or negedge ifRst) begin
            if (!ifRst) begin
               cnt_reg <= '0;
               cmd_reg <= '0;
            end else begin
               if (alloc_mask[gi]) begin
                  cmd_reg <= txn_cmd;
               end
               // Restart the count as the tag enters its op2 cycle
               if (alloc_mask[gi] || (state_reg == SEND1 && cur_tag_reg == 2'(gi))) begin
                  cnt_reg <= '0;
               end else if (busy_reg[gi] && cnt_reg < TO_LIM) begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         assign tag_cmd[gi] = cmd_reg;
         assign expired[gi] = busy_reg[gi] && (cnt_reg >= TO_EXP);
      end
   endgenerate

   always_ff @(posedge ifClk or negedge ifRst) begin
      if (!ifRst) begin
         state_reg    <= IDLE;
         req_cmd_reg  <= '0;
         req_data_reg <= '0;
         req_tag_reg  <= '0;
         op2_reg      <= '0;
         cur_tag_reg  <= '0;
      end else begin
         case (state_reg)
            SEND1: begin
               state_reg    <= SEND2;
               req_cmd_reg  <= '0;
               req_data_reg <= op2_reg;
               req_tag_reg  <= cur_tag_reg;
            end
            default: begin
               if (accept) begin
                  state_reg    <= SEND1;
                  req_cmd_reg  <= txn_cmd;
                  req_data_reg <= txn_op1;
                  req_tag_reg  <= alloc_tag;
                  op2_reg      <= txn_op2;
                  cur_tag_reg  <= alloc_tag;
               end else begin
                  state_reg    <= IDLE;
                  req_cmd_reg  <= '0;
                  req_data_reg <= '0;
                  req_tag_reg  <= '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge ifClk or negedge ifRst) begin
      if (!ifRst) begin
         busy_reg        <= '0;
         outstanding_reg <= '0;
         cpl_valid_reg   <= 1'b0;
         cpl_cmd_reg     <= '0;
         cpl_tag_reg     <= '0;
         cpl_resp_reg    <= '0;
         cpl_data_reg    <= '0;
         cpl_timeout_reg <= 1'b0;
         err_reg         <= 1'b0;
      end else begin
         busy_reg        <= busy_next;
         outstanding_reg <= outstanding_next;
         err_reg         <= resp_bad;
         cpl_valid_reg   <= resp_hit || to_fire;
         if (resp_hit) begin
            cpl_cmd_reg     <= tag_cmd[ifTag_in];
            cpl_tag_reg     <= ifTag_in;
            cpl_resp_reg    <= ifResp_in;
            cpl_data_reg    <= ifData_in;
            cpl_timeout_reg <= 1'b0;
         end else if (to_fire) begin
            cpl_cmd_reg     <= tag_cmd[exp_tag];
            cpl_tag_reg     <= exp_tag;
            cpl_resp_reg    <= '0;
            cpl_data_reg    <= '0;
            cpl_timeout_reg <= 1'b1;
         end else begin
            cpl_cmd_reg     <= '0;
            cpl_tag_reg     <= '0;
            cpl_resp_reg    <= '0;
            cpl_data_reg    <= '0;
            cpl_timeout_reg <= 1'b0;
         end
      end
   end

   assign ifReq_cmd_out  = req_cmd_reg;
   assign ifReq_data_out = req_data_reg;
   assign ifReq_tag_out  = req_tag_reg;
   assign cpl_valid      = cpl_valid_reg;
   assign cpl_cmd        = cpl_cmd_reg;
   assign cpl_tag        = cpl_tag_reg;
   assign cpl_resp       = cpl_resp_reg;
   assign cpl_data       = cpl_data_reg;
   assign cpl_timeout    = cpl_timeout_reg;
   assign err_unexpected = err_reg;
   assign outstanding    = outstanding_reg;

endmodule

// File: tb/tb_calc2_req_port.sv
// Directed bench for calc2_req_port: vector table of single operations plus
// hand-written sequences for tag exhaustion, timeout, collisions and reset.
module tb_calc2_req_port;

   logic        ifClk = 1'b0;
   logic        ifRst = 1'b0;
   logic        txn_valid = 1'b0;
   logic        txn_ready;
   logic [3:0]  txn_cmd = '0;
   logic [31:0] txn_op1 = '0;
   logic [31:0] txn_op2 = '0;
   logic [3:0]  ifReq_cmd_out;
   logic [31:0] ifReq_data_out;
   logic [1:0]  ifReq_tag_out;
   logic [1:0]  ifResp_in = '0;
   logic [31:0] ifData_in = '0;
   logic [1:0]  ifTag_in = '0;
   logic        cpl_valid;
   logic [3:0]  cpl_cmd;
   logic [1:0]  cpl_tag;
   logic [1:0]  cpl_resp;
   logic [31:0] cpl_data;
   logic        cpl_timeout;
   logic        err_unexpected;
   logic [2:0]  outstanding;

   int total = 0;
   int bad   = 0;

   calc2_req_port #(
      .MAX_OUTSTANDING(4),
      .TIMEOUT_CYCLES (16),
      .TO_W           (5)
   ) dut (
      .ifClk         (ifClk),
      .ifRst         (ifRst),
      .txn_valid     (txn_valid),
      .txn_ready     (txn_ready),
      .txn_cmd       (txn_cmd),
      .txn_op1       (txn_op1),
      .txn_op2       (txn_op2),
      .ifReq_cmd_out (ifReq_cmd_out),
      .ifReq_data_out(ifReq_data_out),
      .ifReq_tag_out (ifReq_tag_out),
      .ifResp_in     (ifResp_in),
      .ifData_in     (ifData_in),
      .ifTag_in      (ifTag_in),
      .cpl_valid     (cpl_valid),
      .cpl_cmd       (cpl_cmd),
      .cpl_tag       (cpl_tag),
      .cpl_resp      (cpl_resp),
      .cpl_data      (cpl_data),
      .cpl_timeout   (cpl_timeout),
      .err_unexpected(err_unexpected),
      .outstanding   (outstanding)
   );

   always #5 ifClk = ~ifClk;

   typedef struct {
      logic [3:0]  cmd;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [1:0]  rsp;
      logic [31:0] rdata;
      logic [3:0]  exp_cmd;
      logic [1:0]  exp_resp;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick;
      @(posedge ifClk);
      @(negedge ifClk);
   endtask

   // Offer one op at the current negedge; returns at the negedge of its op2 cycle
   task automatic issue_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] tag);
      txn_valid = 1'b1;
      txn_cmd   = cmd;
      txn_op1   = a;
      txn_op2   = b;
      #1 chk("txn_ready", 32'(txn_ready), 32'd1);
      tick;
      txn_valid = 1'b0;
      chk("send1_cmd", 32'(ifReq_cmd_out), 32'(cmd));
      chk("send1_data", ifReq_data_out, a);
      chk("send1_tag", 32'(ifReq_tag_out), 32'(tag));
      tick;
      chk("send2_cmd", 32'(ifReq_cmd_out), 32'd0);
      chk("send2_data", ifReq_data_out, b);
      chk("send2_tag", 32'(ifReq_tag_out), 32'(tag));
      $display("issue cmd=%0d op1=%0h op2=%0h tag=%0d", cmd, a, b, tag);
   endtask

   task automatic resp_and_check(input logic [1:0] tag, input logic [1:0] rsp, input logic [31:0] rdata,
                                 input logic [3:0] exp_cmd, input logic [1:0] exp_resp,
                                 input logic [31:0] exp_data);
      ifResp_in = rsp;
      ifTag_in  = tag;
      ifData_in = rdata;
      tick;
      ifResp_in = 2'd0;
      chk("cpl_valid", 32'(cpl_valid), 32'd1);
      chk("cpl_tag", 32'(cpl_tag), 32'(tag));
      chk("cpl_cmd", 32'(cpl_cmd), 32'(exp_cmd));
      chk("cpl_resp", 32'(cpl_resp), 32'(exp_resp));
      chk("cpl_data", cpl_data, exp_data);
      chk("cpl_timeout", 32'(cpl_timeout), 32'd0);
      $display("complete tag=%0d cmd=%0d resp=%0d data=%0h", cpl_tag, cpl_cmd, cpl_resp, cpl_data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int early;

      vecs[0] = '{4'd1, 32'd5,          32'd7, 2'd1, 32'd12,  4'd1, 2'd1, 32'd12};
      vecs[1] = '{4'd2, 32'd10,         32'd3, 2'd1, 32'd7,   4'd2, 2'd1, 32'd7};
      vecs[2] = '{4'd5, 32'd1,          32'd4, 2'd1, 32'd16,  4'd5, 2'd1, 32'd16};
      vecs[3] = '{4'd6, 32'd256,        32'd2, 2'd1, 32'd64,  4'd6, 2'd1, 32'd64};
      vecs[4] = '{4'd1, 32'hffff_ffff,  32'd1, 2'd2, 32'd0,   4'd1, 2'd2, 32'd0};
      vecs[5] = '{4'd9, 32'h1234,       32'd1, 2'd2, 32'd0,   4'd9, 2'd2, 32'd0};

      // Reset state
      repeat (3) @(negedge ifClk);
      chk("rst_ready", 32'(txn_ready), 32'd0);
      chk("rst_req_cmd", 32'(ifReq_cmd_out), 32'd0);
      chk("rst_req_data", ifReq_data_out, 32'd0);
      chk("rst_cpl_valid", 32'(cpl_valid), 32'd0);
      chk("rst_err", 32'(err_unexpected), 32'd0);
      chk("rst_outstanding", 32'(outstanding), 32'd0);
      ifRst = 1'b1;
      tick;

      // Vector table: one op at a time, always tag 0
      for (int i = 0; i < 6; i++) begin
         issue_op(vecs[i].cmd, vecs[i].op1, vecs[i].op2, 2'd0);
         chk("vec_outstanding_busy", 32'(outstanding), 32'd1);
         resp_and_check(2'd0, vecs[i].rsp, vecs[i].rdata, vecs[i].exp_cmd, vecs[i].exp_resp,
                        vecs[i].exp_data);
         chk("vec_outstanding_free", 32'(outstanding), 32'd0);
         tick;
         chk("vec_cpl_pulse", 32'(cpl_valid), 32'd0);
      end

      // Tag exhaustion: four back-to-back ops, fifth blocked until tag 2 returns
      issue_op(4'd1, 32'h10, 32'h11, 2'd0);
      issue_op(4'd2, 32'h20, 32'h21, 2'd1);
      issue_op(4'd5, 32'h30, 32'h31, 2'd2);
      issue_op(4'd6, 32'h40, 32'h41, 2'd3);
      txn_valid = 1'b1;
      ifResp_in = 2'd1;
      ifTag_in  = 2'd2;
      ifData_in = 32'h300;
      #1 chk("full_ready", 32'(txn_ready), 32'd0);
      chk("full_outstanding", 32'(outstanding), 32'd4);
      txn_valid = 1'b0;
      tick;
      ifResp_in = 2'd0;
      chk("full_cpl_tag", 32'(cpl_tag), 32'd2);
      chk("full_cpl_cmd", 32'(cpl_cmd), 32'd5);
      chk("full_outstanding_after", 32'(outstanding), 32'd3);
      issue_op(4'd2, 32'h50, 32'h51, 2'd2);
      resp_and_check(2'd0, 2'd1, 32'ha, 4'd1, 2'd1, 32'ha);
      resp_and_check(2'd1, 2'd1, 32'hb, 4'd2, 2'd1, 32'hb);
      resp_and_check(2'd3, 2'd1, 32'hc, 4'd6, 2'd1, 32'hc);
      resp_and_check(2'd2, 2'd1, 32'hd, 4'd2, 2'd1, 32'hd);
      chk("drain_outstanding", 32'(outstanding), 32'd0);
      tick;

      // Timeout exactly 16 cycles after the op2 cycle
      issue_op(4'd1, 32'd3, 32'd4, 2'd0);
      early = 0;
      repeat (15) begin
         tick;
         if (cpl_valid) early++;
      end
      chk("to_no_early_cpl", 32'(early), 32'd0);
      tick;
      chk("to_cpl_valid", 32'(cpl_valid), 32'd1);
      chk("to_cpl_timeout", 32'(cpl_timeout), 32'd1);
      chk("to_cpl_resp", 32'(cpl_resp), 32'd0);
      chk("to_cpl_data", cpl_data, 32'd0);
      chk("to_cpl_cmd", 32'(cpl_cmd), 32'd1);
      chk("to_cpl_tag", 32'(cpl_tag), 32'd0);
      chk("to_outstanding", 32'(outstanding), 32'd0);
      $display("timeout tag=%0d cmd=%0d", cpl_tag, cpl_cmd);
      issue_op(4'd6, 32'd8, 32'd1, 2'd0);
      resp_and_check(2'd0, 2'd1, 32'd4, 4'd6, 2'd1, 32'd4);

      // Illegal responses
      issue_op(4'd1, 32'd1, 32'd1, 2'd0);
      ifResp_in = 2'd1;
      ifTag_in  = 2'd3;
      tick;
      chk("err_free_tag", 32'(err_unexpected), 32'd1);
      chk("err_free_cpl", 32'(cpl_valid), 32'd0);
      chk("err_free_outstanding", 32'(outstanding), 32'd1);
      ifResp_in = 2'd3;
      ifTag_in  = 2'd0;
      tick;
      chk("err_resp3", 32'(err_unexpected), 32'd1);
      chk("err_resp3_cpl", 32'(cpl_valid), 32'd0);
      chk("err_resp3_outstanding", 32'(outstanding), 32'd1);
      ifResp_in = 2'd0;
      tick;
      chk("err_pulse", 32'(err_unexpected), 32'd0);
      $display("unexpected responses checked");
      resp_and_check(2'd0, 2'd1, 32'd2, 4'd1, 2'd1, 32'd2);

      // Response on tag 1 while tag 0 expires: response first, timeout next cycle
      issue_op(4'd1, 32'd1, 32'd2, 2'd0);
      issue_op(4'd2, 32'd9, 32'd3, 2'd1);
      repeat (13) tick;
      ifResp_in = 2'd1;
      ifTag_in  = 2'd1;
      ifData_in = 32'h55;
      tick;
      ifResp_in = 2'd0;
      chk("coll_first_tag", 32'(cpl_tag), 32'd1);
      chk("coll_first_timeout", 32'(cpl_timeout), 32'd0);
      chk("coll_first_data", cpl_data, 32'h55);
      tick;
      chk("coll_second_valid", 32'(cpl_valid), 32'd1);
      chk("coll_second_tag", 32'(cpl_tag), 32'd0);
      chk("coll_second_timeout", 32'(cpl_timeout), 32'd1);
      chk("coll_second_cmd", 32'(cpl_cmd), 32'd1);
      chk("coll_outstanding", 32'(outstanding), 32'd0);
      $display("collision different tags checked");
      tick;
      chk("coll_idle", 32'(cpl_valid), 32'd0);

      // Response and expiry on the same tag: only the response completes
      issue_op(4'd5, 32'd2, 32'd1, 2'd0);
      repeat (15) tick;
      ifResp_in = 2'd1;
      ifTag_in  = 2'd0;
      ifData_in = 32'd4;
      tick;
      ifResp_in = 2'd0;
      chk("same_tag_timeout", 32'(cpl_timeout), 32'd0);
      chk("same_tag_cmd", 32'(cpl_cmd), 32'd5);
      chk("same_tag_data", cpl_data, 32'd4);
      tick;
      chk("same_tag_no_second", 32'(cpl_valid), 32'd0);
      chk("same_tag_outstanding", 32'(outstanding), 32'd0);
      $display("collision same tag checked");

      // Reset during SEND1
      txn_valid = 1'b1;
      txn_cmd   = 4'd2;
      txn_op1   = 32'h77;
      txn_op2   = 32'h1;
      tick;
      txn_valid = 1'b0;
      chk("pre_rst_send1_cmd", 32'(ifReq_cmd_out), 32'd2);
      ifRst = 1'b0;
      #1;
      chk("mid_rst_req_cmd", 32'(ifReq_cmd_out), 32'd0);
      chk("mid_rst_req_data", ifReq_data_out, 32'd0);
      chk("mid_rst_outstanding", 32'(outstanding), 32'd0);
      chk("mid_rst_ready", 32'(txn_ready), 32'd0);
      tick;
      ifRst = 1'b1;
      ifResp_in = 2'd1;
      ifTag_in  = 2'd0;
      tick;
      ifResp_in = 2'd0;
      chk("stale_resp_err", 32'(err_unexpected), 32'd1);
      chk("stale_resp_cpl", 32'(cpl_valid), 32'd0);
      issue_op(4'd1, 32'd6, 32'd6, 2'd0);
      chk("post_rst_outstanding", 32'(outstanding), 32'd1);
      resp_and_check(2'd0, 2'd1, 32'd12, 4'd1, 2'd1, 32'd12);
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
